polar_encoder: RTL

//   Systematic-free polar encoder, the transmit-side counterpart of the polar decoder: x = u * F^{(x)n}, F=[[1,0],[1,1]], no bit reversal.

---
 rtl/polar_encoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/polar_encoder.sv
// Polar encoder: collects K info bits into the non-frozen positions of u, applies
// n in-place butterfly stages (x = u * F^{(x)n}, natural order) and streams N coded bits.
module polar_encoder #(
  parameter int unsigned           CODE_LENGTH        = 1024,
  parameter int unsigned           FROZEN_BITS_LENGTH = 48,
  parameter logic [CODE_LENGTH-1:0] FROZEN_MASK       = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_axi_tdata,
  input  logic s_axi_tvalid,
  input  logic s_axi_tlast,
  output logic s_axi_tready,
  output logic error,
  output logic m_axi_tdata,
  output logic m_axi_tvalid,
  input  logic m_axi_tready,
  output logic m_axi_tlast
);

  localparam int unsigned LOG_N = $clog2(CODE_LENGTH);
  localparam int unsigned IDX_W = LOG_N + 1;
  localparam int unsigned STG_W = LOG_N;

  function automatic int unsigned count_ones(input logic [CODE_LENGTH-1:0] m);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < CODE_LENGTH; i++) begin
      if (m[i]) c = c + 1;
    end
    return c;
  endfunction

  // Highest info (non-frozen) position: the K-th accepted bit lands here.
  function automatic int unsigned last_info_pos(input logic [CODE_LENGTH-1:0] m);
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < CODE_LENGTH; i++) begin
      if (!m[i]) p = i;
    end
    return p;
  endfunction

  localparam bit               MASK_OK  = (count_ones(FROZEN_MASK) == FROZEN_BITS_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(last_info_pos(FROZEN_MASK));
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(CODE_LENGTH);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG_N - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ENCODE,
    ST_OUTPUT
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [STG_W-1:0]        stage, stage_nxt;
  logic [CODE_LENGTH-1:0]  vec, vec_nxt;
  logic                    last_seen, last_seen_nxt;
  logic                    error_nxt;
  logic                    s_ready_nxt;
  logic                    m_valid_nxt, m_data_nxt, m_last_nxt;
  logic                    s_hs, m_hs;
  logic [LOG_N-1:0]        pos, pos_nxt;

  assign pos = idx[LOG_N-1:0];

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_LOAD;
      idx          <= '0;
      stage        <= '0;
      vec          <= '0;
      last_seen    <= 1'b0;
      error        <= 1'b0;
      s_axi_tready <= 1'b0;
      m_axi_tvalid <= 1'b0;
      m_axi_tdata  <= 1'b0;
      m_axi_tlast  <= 1'b0;
    end else begin
      assert (MASK_OK) else $error("polar_encoder: FROZEN_MASK popcount differs from FROZEN_BITS_LENGTH");
      state        <= state_nxt;
      idx          <= idx_nxt;
      stage        <= stage_nxt;
      vec          <= vec_nxt;
      last_seen    <= last_seen_nxt;
      error        <= error_nxt;
      s_axi_tready <= s_ready_nxt;
      m_axi_tvalid <= m_valid_nxt;
      m_axi_tdata  <= m_data_nxt;
      m_axi_tlast  <= m_last_nxt;
    end
  end

  // Next-state, datapath update and next values of the registered outputs
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    stage_nxt     = stage;
    vec_nxt       = vec;
    last_seen_nxt = last_seen;
    error_nxt     = 1'b0;
    s_hs          = s_axi_tvalid && s_axi_tready;
    m_hs          = m_axi_tvalid && m_axi_tready;

    case (state)
      ST_LOAD: begin
        // Frozen positions, and info positions after an early tlast, are zero-filled
        if (FROZEN_MASK[pos] || last_seen) begin
          vec_nxt[pos] = 1'b0;
          idx_nxt      = idx + IDX_W'(1);
        end else if (s_hs) begin
          vec_nxt[pos] = s_axi_tdata;
          idx_nxt      = idx + IDX_W'(1);
          error_nxt    = (s_axi_tlast != (idx == LAST_IDX));
          if (s_axi_tlast) last_seen_nxt = 1'b1;
        end
        if (idx_nxt == N_IDX) begin
          state_nxt     = ST_ENCODE;
          stage_nxt     = '0;
          last_seen_nxt = 1'b0;
        end
      end

      ST_ENCODE: begin
        for (int s = 0; s < int'(LOG_N); s++) begin
          if (stage == STG_W'(s)) begin
            for (int i = 0; i < int'(CODE_LENGTH); i++) begin
              if (((i >> s) & 1) == 0) vec_nxt[i] = vec[i] ^ vec[i + (1 << s)];
            end
          end
        end
        if (stage == LAST_STG) begin
          state_nxt = ST_OUTPUT;
          idx_nxt   = '0;
        end else begin
          stage_nxt = stage + STG_W'(1);
        end
      end

      ST_OUTPUT: begin
        if (m_hs) begin
          if (idx == N_IDX - IDX_W'(1)) begin
            state_nxt = ST_LOAD;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
      end
    endcase

    pos_nxt     = idx_nxt[LOG_N-1:0];
    s_ready_nxt = (state_nxt == ST_LOAD) && !FROZEN_MASK[pos_nxt] && !last_seen_nxt;
    m_valid_nxt = (state_nxt == ST_OUTPUT);
    m_data_nxt  = m_valid_nxt && vec_nxt[pos_nxt];
    m_last_nxt  = m_valid_nxt && (idx_nxt == N_IDX - IDX_W'(1));
  end

endmodule
